// File: rtl/wm_seq_pkg.sv
// rtl/wm_seq_pkg.sv - state, kind and water-level encodings for the wash-cycle sequencer
package wm_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FILL  = 3'd1;
  localparam state_t ST_WASH  = 3'd2;
  localparam state_t ST_RINSE = 3'd3;
  localparam state_t ST_DRAIN = 3'd4;
  localparam state_t ST_DRY   = 3'd5;
  localparam state_t ST_DONE  = 3'd6;
  localparam state_t ST_ERROR = 3'd7;

  // Which phase a FILL is filling for, or a DRAIN is draining from.
  localparam logic KIND_WASH  = 1'b0;
  localparam logic KIND_RINSE = 1'b1;

  localparam logic [1:0] WATER_LOW  = 2'd0;
  localparam logic [1:0] WATER_MID  = 2'd1;
  localparam logic [1:0] WATER_HIGH = 2'd2;

  localparam int TIMER_W = 12;

  function automatic logic is_busy(state_t s);
    return s inside {ST_FILL, ST_WASH, ST_RINSE, ST_DRAIN, ST_DRY};
  endfunction

endpackage

// File: rtl/wm_cycle_seq_if.sv
// rtl/wm_cycle_seq_if.sv - panel/sensor inputs and actuator/indicator outputs of the sequencer
// Optional lid_open input exists only when WM_LID_PAUSE_EN is defined.
interface wm_cycle_seq_if;

  logic        sec_tick;
  logic        start;
  logic        abort;
  logic        wash_en;
  logic        rinse_en;
  logic        dry_en;
  logic [2:0]  rinse_rep;
  logic [1:0]  water_sel;
  logic        us_dist_en;
  logic [7:0]  us_dist;
`ifdef WM_LID_PAUSE_EN
  logic        lid_open;
`endif
  logic        valve_on;
  logic        drain_on;
  logic        motor_on;
  logic        led_wash;
  logic        led_rinse;
  logic        led_dry;
  logic        busy;
  logic        paused;
  logic        done;
  logic        err;
  logic [11:0] remain_sec;
  logic        buz_req;

  modport master (
    output sec_tick, start, abort, wash_en, rinse_en, dry_en, rinse_rep, water_sel,
           us_dist_en, us_dist,
`ifdef WM_LID_PAUSE_EN
    output lid_open,
`endif
    input  valve_on, drain_on, motor_on, led_wash, led_rinse, led_dry,
           busy, paused, done, err, remain_sec, buz_req
  );

  modport slave (
    input  sec_tick, start, abort, wash_en, rinse_en, dry_en, rinse_rep, water_sel,
           us_dist_en, us_dist,
`ifdef WM_LID_PAUSE_EN
    input  lid_open,
`endif
    output valve_on, drain_on, motor_on, led_wash, led_rinse, led_dry,
           busy, paused, done, err, remain_sec, buz_req
  );

endinterface

// File: rtl/wm_phase_timer.sv
// rtl/wm_phase_timer.sv - per-phase seconds down-counter; a load beats a same-cycle tick
module wm_phase_timer
  import wm_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               tick_i,
  input  logic               en_i,
  output logic [TIMER_W-1:0] cnt_o,
  output logic               zero_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/wm_cycle_seq.sv
// rtl/wm_cycle_seq.sv - washing programme sequencer: FILL/WASH/RINSE/DRAIN/DRY on a 1 s tick
// Define WM_LID_PAUSE_EN to add lid_open, which holds the programme like a pause.
module wm_cycle_seq
  import wm_seq_pkg::*;
#(
  parameter int WASH_SEC    = 10,
  parameter int RINSE_SEC   = 6,
  parameter int DRY_SEC     = 8,
  parameter int DRAIN_SEC   = 4,
  parameter int FILL_TO_SEC = 30,
  parameter int LVL_HIGH_CM = 5,
  parameter int LVL_MID_CM  = 10,
  parameter int LVL_LOW_CM  = 15
) (
  input  logic          clk,
  input  logic          rstn,
  wm_cycle_seq_if.slave bus
);

  state_t             state_q, state_d;
  logic               kind_q, kind_d;
  logic [2:0]         rinse_left_q, rinse_left_d;
  logic               paused_q, paused_d;
  logic               buz_q, buz_d;
  logic [TIMER_W-1:0] timer, load_val;
  logic               timer_zero, timer_load;
  logic               busy, hold, run, any_en, level_ok, toggle_ok;
  logic [2:0]         rinse_init;
  logic [7:0]         target_cm;

`ifdef WM_LID_PAUSE_EN
  // The lid overrides the paused flag without touching it, so closing restores it.
  assign hold      = paused_q | bus.lid_open;
  assign toggle_ok = bus.start & ~bus.lid_open;
`else
  assign hold      = paused_q;
  assign toggle_ok = bus.start;
`endif

  assign busy       = is_busy(state_q);
  assign run        = busy & ~hold;
  assign any_en     = bus.wash_en | bus.rinse_en | bus.dry_en;
  assign rinse_init = !bus.rinse_en ? 3'd0 : (bus.rinse_rep == 3'd0) ? 3'd1 : bus.rinse_rep;
  assign level_ok   = bus.us_dist_en && (bus.us_dist <= target_cm);
  assign timer_load = (state_d != state_q);

  always_comb begin
    case (bus.water_sel)
      WATER_LOW: target_cm = 8'(LVL_LOW_CM);
      WATER_MID: target_cm = 8'(LVL_MID_CM);
      default:   target_cm = 8'(LVL_HIGH_CM);
    endcase
  end

  always_comb begin
    case (state_d)
      ST_FILL:  load_val = TIMER_W'(FILL_TO_SEC);
      ST_WASH:  load_val = TIMER_W'(WASH_SEC);
      ST_RINSE: load_val = TIMER_W'(RINSE_SEC);
      ST_DRAIN: load_val = TIMER_W'(DRAIN_SEC);
      ST_DRY:   load_val = TIMER_W'(DRY_SEC);
      default:  load_val = '0;
    endcase
  end

  wm_phase_timer u_timer (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (timer_load),
    .load_val_i (load_val),
    .tick_i     (bus.sec_tick),
    .en_i       (run),
    .cnt_o      (timer),
    .zero_o     (timer_zero)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      kind_q       <= KIND_WASH;
      rinse_left_q <= 3'd0;
      paused_q     <= 1'b0;
      buz_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      rinse_left_q <= rinse_left_d;
      paused_q     <= paused_d;
      buz_q        <= buz_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    rinse_left_d = rinse_left_q;
    paused_d     = paused_q;
    if (bus.abort) begin
      state_d  = ST_IDLE;
      paused_d = 1'b0;
    end else begin
      if (busy && toggle_ok) paused_d = ~paused_q;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (bus.start && any_en) begin
            rinse_left_d = rinse_init;
            paused_d     = 1'b0;
            if (bus.wash_en) begin
              state_d = ST_FILL;
              kind_d  = KIND_WASH;
            end else if (rinse_init != 3'd0) begin
              state_d = ST_FILL;
              kind_d  = KIND_RINSE;
            end else begin
              state_d = ST_DRY;
            end
          end
        end
        ST_FILL: begin
          // A level match in the timeout cycle still counts as filled.
          if (run && level_ok) begin
            state_d = (kind_q == KIND_WASH) ? ST_WASH : ST_RINSE;
          end else if (run && timer_zero) begin
            state_d = ST_ERROR;
          end
        end
        ST_WASH: begin
          if (run && timer_zero) begin
            state_d = ST_DRAIN;
            kind_d  = KIND_WASH;
          end
        end
        ST_RINSE: begin
          if (run && timer_zero) begin
            state_d      = ST_DRAIN;
            kind_d       = KIND_RINSE;
            rinse_left_d = rinse_left_q - 3'd1;
          end
        end
        ST_DRAIN: begin
          if (run && timer_zero) begin
            if (rinse_left_q != 3'd0) begin
              state_d = ST_FILL;
              kind_d  = KIND_RINSE;
            end else if (bus.dry_en) begin
              state_d = ST_DRY;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DRY: begin
          if (run && timer_zero) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
      if (!is_busy(state_d)) paused_d = 1'b0;
    end
  end

  assign buz_d = timer_load && ((state_d == ST_DONE) || (state_d == ST_ERROR));

  always_comb begin
    bus.valve_on   = 1'b0;
    bus.drain_on   = 1'b0;
    bus.motor_on   = 1'b0;
    bus.led_wash   = 1'b0;
    bus.led_rinse  = 1'b0;
    bus.led_dry    = 1'b0;
    case (state_q)
      ST_FILL: begin
        bus.valve_on  = ~hold;
        bus.led_wash  = (kind_q == KIND_WASH);
        bus.led_rinse = (kind_q == KIND_RINSE);
      end
      ST_WASH: begin
        bus.motor_on = ~hold;
        bus.led_wash = 1'b1;
      end
      ST_RINSE: begin
        bus.motor_on  = ~hold;
        bus.led_rinse = 1'b1;
      end
      ST_DRAIN: begin
        bus.drain_on  = ~hold;
        bus.led_wash  = (kind_q == KIND_WASH);
        bus.led_rinse = (kind_q == KIND_RINSE);
      end
      ST_DRY: begin
        bus.drain_on = ~hold;
        bus.motor_on = ~hold;
        bus.led_dry  = 1'b1;
      end
      default: ;
    endcase
    bus.busy       = busy;
    bus.paused     = busy & hold;
    bus.done       = (state_q == ST_DONE);
    bus.err        = (state_q == ST_ERROR);
    bus.remain_sec = timer;
    bus.buz_req    = buz_q;
  end

endmodule

// File: tb/tb_wm_cycle_seq.sv
// tb/tb_wm_cycle_seq.sv - scoreboard bench: expected phase list per programme vs observed phases
// Drives lid_open low when WM_LID_PAUSE_EN is defined.
module tb_wm_cycle_seq;

  localparam int P_IDLE = 0, P_FILL_W = 1, P_FILL_R = 2, P_WASH = 3, P_RINSE = 4;
  localparam int P_DRAIN_W = 5, P_DRAIN_R = 6, P_DRY = 7, P_DONE = 8, P_ERR = 9;

  typedef struct { int ph; int remain; int ticks; } exp_t;

  exp_t exp_q[$];
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_tests = 0, n_fail = 0;
  int   buz_cnt = 0;
  int   cur_ph = P_IDLE;
  int   fill_k = 3;
  int   target = 10;

  wm_cycle_seq_if bus ();

  wm_cycle_seq dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #4 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {9'd0, bus.valve_on, bus.drain_on, bus.motor_on, bus.led_wash, bus.led_rinse,
            bus.led_dry, bus.busy, bus.paused, bus.done, bus.err, bus.buz_req, bus.remain_sec};
  endfunction

  function automatic int decode();
    if (bus.err) return P_ERR;
    if (bus.done) return P_DONE;
    if (!bus.busy) return P_IDLE;
    if (bus.valve_on) return bus.led_wash ? P_FILL_W : P_FILL_R;
    if (bus.drain_on && bus.motor_on) return P_DRY;
    if (bus.drain_on) return bus.led_wash ? P_DRAIN_W : P_DRAIN_R;
    if (bus.motor_on) return bus.led_wash ? P_WASH : P_RINSE;
    return -1;
  endfunction

  function automatic int tgt(input logic [1:0] ws);
    return (ws == 2'd0) ? 15 : (ws == 2'd1) ? 10 : 5;
  endfunction

  // Reference: the programme as an ordered list of (phase, seconds at entry, ticks spent).
  task automatic model_push(input bit w, input bit r, input bit d, input int rep, input int k);
    int nr, fk;
    nr = r ? ((rep == 0) ? 1 : rep) : 0;
    fk = (k == 0) ? 30 : k;
    if (!(w || r || d)) return;
    if (w) begin
      exp_q.push_back('{P_FILL_W, 30, fk});
      if (k == 0) begin exp_q.push_back('{P_ERR, 0, -1}); return; end
      exp_q.push_back('{P_WASH, 10, 10});
      exp_q.push_back('{P_DRAIN_W, 4, 4});
    end
    for (int i = 0; i < nr; i++) begin
      exp_q.push_back('{P_FILL_R, 30, fk});
      if (k == 0) begin exp_q.push_back('{P_ERR, 0, -1}); return; end
      exp_q.push_back('{P_RINSE, 6, 6});
      exp_q.push_back('{P_DRAIN_R, 4, 4});
    end
    if (d) exp_q.push_back('{P_DRY, 8, 8});
    exp_q.push_back('{P_DONE, 0, -1});
  endtask

  initial begin
    bus.sec_tick = 1'b0;
    forever begin
      repeat ($urandom_range(3, 6)) @(posedge clk);
      #1 bus.sec_tick = 1'b1;
      @(posedge clk);
      #1 bus.sec_tick = 1'b0;
    end
  end

  // Water model: surface reaches the target fill_k ticks into each FILL (never if 0).
  initial begin
    int  fcnt;
    bit  in_fill, set;
    fcnt = 0; in_fill = 0; set = 0;
    bus.us_dist = 8'd40; bus.us_dist_en = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.valve_on) begin
        if (!in_fill) begin in_fill = 1; fcnt = 0; set = 0; end
        if (bus.sec_tick) fcnt++;
        if (fill_k != 0 && fcnt == fill_k && !set) begin
          set = 1;
          @(posedge clk);
          #1;
          if ($urandom_range(0, 1) == 1) begin
            bus.us_dist = 8'(target + 1); bus.us_dist_en = 1'b1;
          end else begin
            bus.us_dist = 8'd0; bus.us_dist_en = 1'b0;
          end
          @(posedge clk);
          #1 bus.us_dist = 8'(target - int'($urandom_range(0, 2))); bus.us_dist_en = 1'b1;
        end
      end else if (in_fill && !bus.paused) begin
        in_fill = 0;
        bus.us_dist = 8'd40; bus.us_dist_en = 1'b1;
      end
    end
  end

  // Monitor: every phase entry pops one expectation; every exit checks the ticks spent.
  initial begin
    int   ph, tcnt, exp_ticks;
    exp_t e;
    tcnt = 0; exp_ticks = -1;
    forever begin
      @(negedge clk);
      if (bus.buz_req) buz_cnt++;
      ph = bus.paused ? cur_ph : decode();
      if (ph != cur_ph) begin
        if (ph != P_IDLE && exp_ticks >= 0) check("phase_ticks", tcnt, exp_ticks);
        exp_ticks = -1;
        if (ph != P_IDLE) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_phase: got phase %0d expected none", ph);
          end else begin
            e = exp_q.pop_front();
            check("sb_phase", ph, e.ph);
            check("sb_remain_entry", bus.remain_sec, e.remain);
            exp_ticks = e.ticks;
          end
        end
        cur_ph = ph;
        tcnt = (bus.sec_tick && !bus.paused) ? 1 : 0;
      end else if (bus.sec_tick && !bus.paused) begin
        tcnt++;
      end
    end
  end

  task automatic pulse(input bit s, input bit a);
    @(posedge clk);
    #1 bus.start = s; bus.abort = a;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.abort = 1'b0;
  endtask

  task automatic setup(input bit w, input bit r, input bit d, input int rep, input int ws, input int k);
    bus.wash_en = w; bus.rinse_en = r; bus.dry_en = d;
    bus.rinse_rep = 3'(rep); bus.water_sel = 2'(ws);
    target = tgt(2'(ws)); fill_k = k;
    model_push(w, r, d, rep, k);
  endtask

  task automatic wait_phase(input int p, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (decode() == p) ok = 1;
    end
    check(name, ok, 1);
  endtask

  task automatic finish_prog(input int b0, input bit exp_done);
    bit ok;
    ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (bus.done || bus.err) ok = 1;
    end
    check("prog_end", bus.done | bus.err, 1);
    repeat (2) @(negedge clk);
    check("done", bus.done, exp_done);
    check("err", bus.err, !exp_done);
    if (!exp_done) check("err_valve_off", bus.valve_on, 0);
    check("buz_once", buz_cnt - b0, 1);
    check("sb_drained", exp_q.size(), 0);
    if (!ok) begin
      pulse(1'b0, 1'b1);
      exp_q.delete();
    end
  endtask

  task automatic run_prog(input bit w, input bit r, input bit d, input int rep, input int ws, input int k);
    int  b0, nr;
    bit  exp_done;
    nr = r ? ((rep == 0) ? 1 : rep) : 0;
    exp_done = !(k == 0 && (w || nr > 0));
    setup(w, r, d, rep, ws, k);
    b0 = buz_cnt;
    pulse(1'b1, 1'b0);
    finish_prog(b0, exp_done);
  endtask

  initial begin
    int b0, tk;
    bus.start = 0; bus.abort = 0; bus.wash_en = 0; bus.rinse_en = 0; bus.dry_en = 0;
    bus.rinse_rep = 0; bus.water_sel = 0;
`ifdef WM_LID_PAUSE_EN
    bus.lid_open = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", out_vec(), 0);
    rstn = 1'b1;

    run_prog(1, 1, 1, 2, 1, 3);
    run_prog(1, 0, 0, 0, 1, 0);

    // Pause in WASH at 7 s, sit out 5 ticks, resume.
    setup(1, 0, 0, 0, 2, 2);
    b0 = buz_cnt;
    pulse(1'b1, 1'b0);
    begin
      bit ok;
      ok = 0;
      for (int i = 0; i < 4000 && !ok; i++) begin
        @(negedge clk);
        if (decode() == P_WASH && bus.remain_sec == 12'd7) ok = 1;
      end
      check("pause_reach_7", ok, 1);
    end
    pulse(1'b1, 1'b0);
    @(negedge clk);
    check("pause_paused", bus.paused, 1);
    check("pause_motor_off", bus.motor_on, 0);
    tk = 0;
    for (int i = 0; i < 200 && tk < 5; i++) begin
      @(negedge clk);
      if (bus.sec_tick) tk++;
    end
    check("pause_frozen", bus.remain_sec, 7);
    pulse(1'b1, 1'b0);
    tk = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (decode() != P_WASH) break;
      if (bus.sec_tick) tk++;
    end
    check("pause_resume_ticks", tk, 7);
    finish_prog(b0, 1'b1);

    // Abort and start together during RINSE.
    setup(0, 1, 1, 3, 0, 2);
    pulse(1'b1, 1'b0);
    wait_phase(P_RINSE, "abort_reach_rinse");
    pulse(1'b1, 1'b1);
    @(negedge clk);
    check("abort_outputs", out_vec(), 0);
    repeat (3) @(negedge clk);
    check("abort_stays_idle", out_vec(), 0);
    exp_q.delete();

    // Nothing enabled: start ignored.
    setup(0, 0, 0, 5, 1, 1);
    pulse(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("no_phase_idle", out_vec(), 0);

    // Asynchronous reset while draining.
    setup(1, 0, 1, 0, 1, 1);
    pulse(1'b1, 1'b0);
    wait_phase(P_DRAIN_W, "reset_reach_drain");
    @(posedge clk);
    #1 rstn = 1'b0;
    #1 check("async_reset_outputs", out_vec(), 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("idle_after_reset", out_vec(), 0);
    exp_q.delete();

    run_prog(0, 0, 1, 0, 3, 1);

    for (int n = 0; n < 8; n++) begin
      bit w, r, d;
      int k;
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      if (!(w || r || d)) d = 1;
      k = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      run_prog(w, r, d, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), k);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wm_cycle_seq.md
Name: wm_cycle_seq

Overview:
- Washing-cycle sequencer between the control-panel settings block and the actuators, LEDs, FND and buzzer.
- Runs the programme WASH -> RINSE x N -> DRY on a 1-second tick. Each wash/rinse is preceded by FILL and followed by DRAIN.
- FILL is closed-loop on the ultrasonic distance. All other phase timing is open-loop on second counts.
- Exports the remaining seconds of the current phase for the FND, and requests a buzzer beep on completion or error.

Parameters:
WASH_SEC, 10, wash agitation duration (s)
RINSE_SEC, 6, duration of each rinse (s)
DRY_SEC, 8, spin-dry duration (s)
DRAIN_SEC, 4, drain duration (s)
FILL_TO_SEC, 30, fill timeout (s)
LVL_HIGH_CM, 5, sensor distance at or below which the HIGH level is reached
LVL_MID_CM, 10, same, for MID
LVL_LOW_CM, 15, same, for LOW

Ports:
clk  in  1  system clock, 125 MHz
rstn  in  1  asynchronous active-low reset
sec_tick  in  1  one-cycle strobe, once per second
start  in  1  one-cycle pulse: start the programme, or toggle pause while running
abort  in  1  one-cycle pulse: abandon the programme
wash_en / rinse_en / dry_en  in  1 each  phase selections
rinse_rep  in  3  number of rinses; 0 is treated as 1
water_sel  in  2  fill target: 0=LOW, 1=MID, 2=HIGH, 3=HIGH
us_dist_en  in  1  us_dist is valid this cycle
us_dist  in  8  water-surface distance in cm
valve_on / drain_on / motor_on  out  1 each  actuator enables
led_wash / led_rinse / led_dry  out  1 each  current-phase indicators
busy  out  1  programme in progress, including while paused
paused  out  1  programme paused
done  out  1  programme completed; held
err  out  1  fill timeout occurred; held
remain_sec  out  12  seconds left in the current phase
buz_req  out  1  one-cycle beep request

Behaviour:
- Reset: state IDLE. All outputs 0; internal counters 0. Reset mid-programme returns to IDLE immediately.
- States: IDLE, FILL, WASH, RINSE, DRAIN, DRY, DONE, ERROR.
- Registers: kind (WASH or RINSE, the phase being filled for or drained from); rinse_left (3 bits); timer (12 bits, equal to remain_sec).
- Start from IDLE, DONE or ERROR:
  - Ignored if no phase is enabled.
  - Otherwise clears done/err, loads rinse_left = max(rinse_rep, 1) when rinse_en, else 0.
  - Enters FILL (kind=WASH) if wash_en; else FILL (kind=RINSE) if rinse_left>0; else DRY.
- Timed states (WASH, RINSE, DRAIN, DRY):
  - Timer loads the phase duration on entry.
  - Decrements on each sec_tick when not paused.
  - The tick taking the timer from 1 to 0 moves to the next state on the following clock. A phase of N seconds therefore lasts exactly N ticks.
- FILL:
  - Timer loads FILL_TO_SEC.
  - Exits to WASH or RINSE, according to kind, on the first cycle with us_dist_en=1 and us_dist <= target cm.
  - Timer expiry goes to ERROR. A level match on the same cycle as timeout wins.
- WASH -> DRAIN. RINSE -> DRAIN, and decrements rinse_left on entry to DRAIN.
- DRAIN exit: FILL (kind=RINSE) if rinse_left>0; else DRY if dry_en; else DONE.
- DRY -> DONE.
- DONE: done=1, one buz_req pulse on entry, remain_sec=0.
- ERROR: err=1, all actuators off, one buz_req pulse on entry.
- Outputs by state:
  - valve_on only in FILL.
  - drain_on in DRAIN and DRY.
  - motor_on in WASH, RINSE and DRY.
  - LEDs follow kind during FILL/DRAIN, and the state otherwise.
- Pause: start while busy toggles paused.
  - Paused forces all actuators to 0 and freezes the timer.
  - FILL level checking is suspended while paused.
- Abort: from any state goes to IDLE and clears paused/done/err. Abort has priority over a simultaneous start.
- busy=1 in FILL..DRY.
- sec_tick coinciding with state entry is ignored, because the load wins.

Optional Feature:
WM_LID_PAUSE_EN:
- Enabled: adds input lid_open (1 bit, assumed synchronous).
  - While lid_open=1 and busy: behaves as paused, and start cannot resume.
  - When lid_open falls, the prior paused flag is restored.
- Disabled: no port, no logic.

Decomposition:
- Package wm_seq_pkg: state encoding localparams, kind encoding, water_sel codes.
- Optional sub-module wm_phase_timer: load / tick / enable / expire, 12-bit down-counter.

Test Plan:
- wash_en=1, rinse_en=1, rinse_rep=2, dry_en=1, water_sel=MID; us_dist drops to 10 three ticks into each FILL. Required visit order: FILL, WASH(10 ticks), DRAIN(4), FILL, RINSE(6), DRAIN, FILL, RINSE, DRAIN, DRY(8), DONE. Also require done=1 and exactly one buz_req.
- FILL with us_dist stuck at 40 -> ERROR after 30 ticks, err=1, valve_on=0, one buz_req.
- Start pulse in WASH at remain_sec=7 -> paused=1, motor_on=0; 5 ticks later remain_sec is still 7; start again -> resume; WASH ends 7 ticks later.
- Abort and start on the same cycle during RINSE -> IDLE, all outputs 0.
- Only dry_en=1 -> DRY directly with remain_sec=8, then DONE. With no phase enabled, start is ignored and the block stays in IDLE.
- Reset asserted mid-DRAIN -> all outputs 0 asynchronously; after release the block is in IDLE.
